// File: rtl/regfile_pkg.sv
// Shared register-file types and widths used by the writeback arbiter and its testbench.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int DATA_W     = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic              valid;
        reg_addr_t         addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after ptr_i
// (wrapping modulo N) wins; gnt_o is one-hot or zero.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic          found;
    logic [IW:0]   pos;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr_i} + (IW+1)'(k);
            if (pos >= (IW+1)'(N)) begin
                pos = pos - (IW+1)'(N);
            end
            if (!found && req_i[pos[IW-1:0]]) begin
                found               = 1'b1;
                gnt_o[pos[IW-1:0]] = 1'b1;
                idx_o               = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin share of the register-file write port with a one-deep staging register.
// Define REGFILE_ARB_PRIO0_EN to make requester 0 fixed highest priority (others may starve).
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int N_Bits = 32,
    parameter int N_REQ  = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [REG_ADDR_W*N_REQ-1:0]   req_addr,
    input  logic [N_Bits*N_REQ-1:0]       req_data,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          WE3,
    output logic [REG_ADDR_W-1:0]         A3,
    output logic [N_Bits-1:0]             WD3,
    output logic [NUM_REGS-1:0]           pend_mask,
    output logic [$clog2(N_REQ)-1:0]      grant_id
);

    localparam int             IW       = $clog2(N_REQ);
    localparam logic [IW-1:0]  LAST_IDX = IW'(N_REQ - 1);

    reg_addr_t          addr_lane [N_REQ];
    logic [N_Bits-1:0]  data_lane [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign addr_lane[gi] = req_addr[REG_ADDR_W*gi +: REG_ADDR_W];
            assign data_lane[gi] = req_data[N_Bits*gi +: N_Bits];
        end
    endgenerate

    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]   gnt;
    logic [IW-1:0]      gnt_idx;
    logic               any_gnt;
    logic               ptr_adv;

`ifdef REGFILE_ARB_PRIO0_EN
    logic [N_REQ-1:0]   rr_gnt;
    logic [IW-1:0]      rr_idx;

    // Requester 0 is masked out of the rotation; it pre-empts whenever valid.
    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr_arbiter (
        .req_i (req_valid & ~N_REQ'(1)),
        .ptr_i (rr_ptr_q),
        .gnt_o (rr_gnt),
        .idx_o (rr_idx)
    );

    assign gnt     = req_valid[0] ? N_REQ'(1) : rr_gnt;
    assign gnt_idx = req_valid[0] ? '0 : rr_idx;
    assign any_gnt = |gnt;
    assign ptr_adv = any_gnt && (gnt_idx != '0);
`else
    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr_arbiter (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    assign any_gnt = |gnt;
    assign ptr_adv = any_gnt;
`endif

    assign req_ready = rst_n ? gnt : '0;

    logic               we_q, we_d;
    reg_addr_t          a3_q, a3_d;
    logic [N_Bits-1:0]  wd3_q, wd3_d;
    logic [IW-1:0]      gid_q, gid_d;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        we_d     = 1'b0;
        a3_d     = a3_q;
        wd3_d    = wd3_q;
        gid_d    = gid_q;
        if (ptr_adv) begin
            rr_ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
        end
        if (any_gnt) begin
            a3_d  = addr_lane[gnt_idx];
            wd3_d = data_lane[gnt_idx];
            gid_d = gnt_idx;
            // x0 is hardwired: accept the handshake but never enable the write.
            we_d  = (addr_lane[gnt_idx] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            we_q     <= 1'b0;
            a3_q     <= '0;
            wd3_q    <= '0;
            gid_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            we_q     <= we_d;
            a3_q     <= a3_d;
            wd3_q    <= wd3_d;
            gid_q    <= gid_d;
        end
    end

    assign WE3       = we_q;
    assign A3        = a3_q;
    assign WD3       = wd3_q;
    assign grant_id  = gid_q;
    assign pend_mask = we_q ? (NUM_REGS'(1) << a3_q) : '0;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench: the driver predicts each cycle's staged write from a reference model,
// a posedge monitor pops and compares the DUT's write port.
module tb_regfile_wr_arbiter;
    import regfile_pkg::*;

    localparam int N = 3;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [5*N-1:0] req_addr;
    logic [32*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           WE3;
    logic [4:0]     A3;
    logic [31:0]    WD3;
    logic [31:0]    pend_mask;
    logic [1:0]     grant_id;

    regfile_wr_arbiter #(.N_Bits(32), .N_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .WE3       (WE3),
        .A3        (A3),
        .WD3       (WD3),
        .pend_mask (pend_mask),
        .grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd3;
        logic [1:0]  gid;
    } exp_t;

    exp_t    exp_q[$];
    exp_t    mon_e;
    wr_req_t lanes [N];

    int total = 0;
    int bad   = 0;

    int          m_ptr;
    logic [4:0]  m_a3;
    logic [31:0] m_wd3;
    logic [1:0]  m_gid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] v);
`ifdef REGFILE_ARB_PRIO0_EN
        if (v[0]) return 0;
        for (int k = 0; k < N; k++) begin
            if (((m_ptr + k) % N) != 0 && v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
`else
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
`endif
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_a3  = '0;
        m_wd3 = '0;
        m_gid = '0;
    endtask

    task automatic pack_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = lanes[i].valid;
            req_addr[5*i +: 5]    = lanes[i].addr;
            req_data[32*i +: 32]  = lanes[i].data;
        end
    endtask

    task automatic set_lane(input int i, input logic [4:0] a, input logic [31:0] d);
        lanes[i].valid = 1'b1;
        lanes[i].addr  = a;
        lanes[i].data  = d;
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < N; i++) lanes[i].valid = 1'b0;
    endtask

    // One arbitration cycle: drive, predict, check the grant, queue the staged write.
    task automatic drive_cycle(output int w);
        exp_t       e;
        logic [N-1:0] v;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        pack_inputs();
        #1;
        v = req_valid;
        w = model_pick(v);
        exp_ready = (w >= 0) ? N'(1 << w) : '0;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        e.we = 1'b0;
        if (w >= 0) begin
            m_a3  = lanes[w].addr;
            m_wd3 = lanes[w].data;
            m_gid = 2'(w);
            e.we  = (lanes[w].addr != 5'd0);
`ifdef REGFILE_ARB_PRIO0_EN
            if (w != 0) m_ptr = (w + 1) % N;
`else
            m_ptr = (w + 1) % N;
`endif
            lanes[w].valid = 1'b0;
        end
        e.a3  = m_a3;
        e.wd3 = m_wd3;
        e.gid = m_gid;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("WE3", 64'(WE3), 64'(mon_e.we));
            chk("A3", 64'(A3), 64'(mon_e.a3));
            chk("WD3", 64'(WD3), 64'(mon_e.wd3));
            chk("grant_id", 64'(grant_id), 64'(mon_e.gid));
            chk("pend_mask", 64'(pend_mask), 64'(mon_e.we ? (32'(1) << mon_e.a3) : 32'd0));
            $display("wr t=%0t we=%0b a3=%0d wd3=%08h gid=%0d", $time, WE3, A3, WD3, grant_id);
        end else begin
            chk("idle_WE3", 64'(WE3), 64'(0));
        end
    end

    initial begin
        int w;
        rst_n     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        for (int i = 0; i < N; i++) lanes[i] = '0;
        model_reset();
        #1 rst_n = 1'b0;

        // Reset with every requester asking: no grants, port idle.
        set_lane(0, 5'd1, 32'h1111_0000);
        set_lane(1, 5'd2, 32'h2222_0000);
        set_lane(2, 5'd3, 32'h3333_0000);
        pack_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_WE3", 64'(WE3), 64'(0));
        chk("rst_pend_mask", 64'(pend_mask), 64'(0));
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Round-robin with all three continuously valid.
        for (int c = 0; c < 6; c++) begin
            set_lane(0, 5'd1, 32'h1111_0000 + 32'(c));
            set_lane(1, 5'd2, 32'h2222_0000 + 32'(c));
            set_lane(2, 5'd3, 32'h3333_0000 + 32'(c));
            drive_cycle(w);
        end
        clear_lanes();
        drive_cycle(w);

        // Single write from requester 1.
        set_lane(1, 5'd7, 32'hDEAD_BEEF);
        drive_cycle(w);
        drive_cycle(w);

        // x0 write is accepted but never enabled.
        set_lane(2, 5'd0, 32'd5);
        drive_cycle(w);
        drive_cycle(w);

        // Same register from two requesters back to back.
        set_lane(0, 5'd9, 32'hAAAA_0001);
        set_lane(1, 5'd9, 32'hBBBB_0002);
        drive_cycle(w);
        drive_cycle(w);
        drive_cycle(w);

        // Mid-operation reset discards the staged write to register 4.
        set_lane(1, 5'd4, 32'h4444_4444);
        drive_cycle(w);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        set_lane(0, 5'd10, 32'h0A0A_0A0A);
        set_lane(2, 5'd12, 32'h0C0C_0C0C);
        pack_inputs();
        #1;
        chk("midrst_WE3", 64'(WE3), 64'(0));
        chk("midrst_pend_mask", 64'(pend_mask), 64'(0));
        chk("midrst_req_ready", 64'(req_ready), 64'(0));
        exp_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        drive_cycle(w);
        drive_cycle(w);
        clear_lanes();
        drive_cycle(w);

        // Requesters 0 and 2 competing, then 0 withdraws.
        for (int c = 0; c < 3; c++) begin
            set_lane(0, 5'd20, 32'h2000_0000 + 32'(c));
            if (!lanes[2].valid) set_lane(2, 5'd22, 32'h2200_0000 + 32'(c));
            drive_cycle(w);
        end
        lanes[0].valid = 1'b0;
        if (!lanes[2].valid) set_lane(2, 5'd23, 32'h2300_0000);
        drive_cycle(w);
        clear_lanes();
        drive_cycle(w);

        // Random traffic; each requester holds its request until granted.
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!lanes[i].valid && $urandom_range(0, 99) < 55) begin
                    set_lane(i, 5'($urandom_range(0, 31)), $urandom);
                end
            end
            drive_cycle(w);
        end
        clear_lanes();
        repeat (3) drive_cycle(w);

        @(posedge clk);
        #4;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
